// File: rtl/alu_pkg.sv
// Opcode encoding and legality check shared by the alu, its arbiter front-end and the bench.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_OP_MAX = 4'd9;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational alu; compare flags are always produced regardless of opcode.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  opcode,
  output logic [31:0] result,
  output logic        lt,
  output logic        ltu,
  output logic        eq
);

  assign lt  = $signed(op1) < $signed(op2);
  assign ltu = op1 < op2;
  assign eq  = op1 == op2;

  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_SLL:  result = op1 << op2[4:0];
      ALU_SLT:  result = {31'd0, lt};
      ALU_SLTU: result = {31'd0, ltu};
      ALU_XOR:  result = op1 ^ op2;
      ALU_SRL:  result = op1 >> op2[4:0];
      ALU_SRA:  result = $signed(op1) >>> op2[4:0];
      ALU_OR:   result = op1 | op2;
      ALU_AND:  result = op1 & op2;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr (the last winner).
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NREQ);

  logic             found;
  logic [IDX_W-1:0] cand;
  int               pos;

  // idx stays valid even when en is low so the operand mux keeps a stable source
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    pos   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      pos  = (int'(ptr) + k) % NREQ;
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    gnt = '0;
    if (found && en) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between NREQ requesters; result lands in a one-entry response register
// tagged with the requester id. One op per cycle, one cycle latency.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [32*NREQ-1:0]      req_op1,
  input  logic [32*NREQ-1:0]      req_op2,
  input  logic [4*NREQ-1:0]       req_opcode,
  input  logic [TAG_W*NREQ-1:0]   req_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_result,
  output logic                    rsp_lt,
  output logic                    rsp_ltu,
  output logic                    rsp_eq,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    rsp_err
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [NREQ-1:0]  gnt;
  logic             can_accept;
  logic             hs;

  logic [31:0]      alu_op1;
  logic [31:0]      alu_op2;
  logic [3:0]       alu_opcode;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      alu_result;
  logic             alu_lt;
  logic             alu_ltu;
  logic             alu_eq;

  // a slot draining this cycle can be refilled in the same cycle
  assign can_accept = !rsp_valid || rsp_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (can_accept),
    .gnt (gnt),
    .idx (idx)
  );

  assign req_ready = rst_n ? gnt : '0;
  assign hs        = |(req_valid & req_ready);

  // with no requester valid idx is 0, so requester 0 drives the alu
  always_comb begin
    alu_op1    = req_op1[31:0];
    alu_op2    = req_op2[31:0];
    alu_opcode = req_opcode[3:0];
    sel_tag    = req_tag[TAG_W-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (idx == IDX_W'(i)) begin
        alu_op1    = req_op1[32*i +: 32];
        alu_op2    = req_op2[32*i +: 32];
        alu_opcode = req_opcode[4*i +: 4];
        sel_tag    = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  alu u_alu (
    .op1    (alu_op1),
    .op2    (alu_op2),
    .opcode (alu_opcode),
    .result (alu_result),
    .lt     (alu_lt),
    .ltu    (alu_ltu),
    .eq     (alu_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= IDX_W'(NREQ - 1);
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_lt     <= 1'b0;
      rsp_ltu    <= 1'b0;
      rsp_eq     <= 1'b0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else if (hs) begin
      ptr        <= idx;
      rsp_valid  <= 1'b1;
      rsp_result <= is_legal_op(alu_opcode) ? alu_result : '0;
      rsp_lt     <= alu_lt;
      rsp_ltu    <= alu_ltu;
      rsp_eq     <= alu_eq;
      rsp_id     <= idx;
      rsp_tag    <= sel_tag;
      rsp_err    <= !is_legal_op(alu_opcode);
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random checks of alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ  = 2;
  localparam int TAG_W = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [32*NREQ-1:0]      req_op1;
  logic [32*NREQ-1:0]      req_op2;
  logic [4*NREQ-1:0]       req_opcode;
  logic [TAG_W*NREQ-1:0]   req_tag;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [31:0]             rsp_result;
  logic                    rsp_lt;
  logic                    rsp_ltu;
  logic                    rsp_eq;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [TAG_W-1:0]        rsp_tag;
  logic                    rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: last winner and the expected contents of the response register
  int               m_ptr;
  bit               m_valid;
  logic [31:0]      m_result;
  bit               m_lt, m_ltu, m_eq, m_err;
  int               m_id;
  logic [TAG_W-1:0] m_tag;

  alu_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opcode (req_opcode),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_lt     (rsp_lt),
    .rsp_ltu    (rsp_ltu),
    .rsp_eq     (rsp_eq),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = NREQ - 1; m_valid = 0; m_result = '0;
    m_lt = 0; m_ltu = 0; m_eq = 0; m_err = 0; m_id = 0; m_tag = '0;
  endtask

  // spec-level alu: signed compare by sign-flip, arithmetic shift via 64-bit extension
  task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input int opc,
                         output logic [31:0] r, output bit lt, output bit ltu, output bit eq);
    logic [63:0] ext;
    int sh;
    sh  = int'(b[4:0]);
    lt  = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    ltu = a < b;
    eq  = a == b;
    ext = {{32{a[31]}}, a};
    case (opc)
      0: r = a + b;
      1: r = a - b;
      2: r = a << sh;
      3: r = lt ? 32'd1 : 32'd0;
      4: r = ltu ? 32'd1 : 32'd0;
      5: r = a ^ b;
      6: r = a >> sh;
      7: r = 32'(ext >> sh);
      8: r = a | b;
      9: r = a & b;
      default: r = 32'd0;
    endcase
  endtask

  function automatic int exp_winner();
    int c;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      c = (m_ptr + k) % NREQ;
      if (((req_valid >> c) & NREQ'(1)) != 0) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] opc, input logic [TAG_W-1:0] tg);
    req_op1[32*i +: 32]       = a;
    req_op2[32*i +: 32]       = b;
    req_opcode[4*i +: 4]      = opc;
    req_tag[TAG_W*i +: TAG_W] = tg;
  endtask

  task automatic check_rsp(input string name);
    check({name, ".valid"},  64'(rsp_valid),  64'(m_valid));
    check({name, ".result"}, 64'(rsp_result), 64'(m_result));
    check({name, ".lt"},     64'(rsp_lt),     64'(m_lt));
    check({name, ".ltu"},    64'(rsp_ltu),    64'(m_ltu));
    check({name, ".eq"},     64'(rsp_eq),     64'(m_eq));
    check({name, ".id"},     64'(rsp_id),     64'(m_id));
    check({name, ".tag"},    64'(rsp_tag),    64'(m_tag));
    check({name, ".err"},    64'(rsp_err),    64'(m_err));
  endtask

  // called just after a negedge with inputs already driven; returns at the next negedge
  task automatic step(input string name);
    int w;
    logic [NREQ-1:0] er;
    logic [31:0] a, b;
    int opc;
    #1;
    w  = exp_winner();
    er = (w < 0) ? '0 : NREQ'(1) << w;
    check({name, ".ready"}, 64'(req_ready), 64'(er));
    @(posedge clk);
    if (w >= 0) begin
      a   = 32'(req_op1 >> (32*w));
      b   = 32'(req_op2 >> (32*w));
      opc = int'(4'(req_opcode >> (4*w)));
      ref_alu(a, b, opc, m_result, m_lt, m_ltu, m_eq);
      m_err   = !is_legal_op(4'(opc));
      m_id    = w;
      m_tag   = TAG_W'(req_tag >> (TAG_W*w));
      m_ptr   = w;
      m_valid = 1;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
    check_rsp(name);
    @(negedge clk);
  endtask

  initial begin
    int order [4] = '{0, 1, 0, 1};
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1;
    req_op1 = '0; req_op2 = '0; req_opcode = '0; req_tag = '0;
    model_reset();
    #3;
    check("rst.ready", 64'(req_ready), 64'(0));
    check_rsp("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    @(negedge clk);

    // single ADD
    set_req(0, 32'h55555, 32'hAAAAA, ALU_ADD, 4'd3);
    req_valid = 2'b01;
    step("t1");
    check("t1.result_c", 64'(rsp_result), 64'h000F_FFFF);
    check("t1.tag_c",    64'(rsp_tag),    64'd3);
    req_valid = '0;
    step("t1.idle");

    // solo from requester 1 so the contention run starts at requester 0
    set_req(1, 32'd100, 32'd1, ALU_SUB, 4'd9);
    req_valid = 2'b10;
    step("t2.pre");

    set_req(0, 32'd7, 32'd5, ALU_ADD, 4'd1);
    set_req(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_XOR, 4'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step("t2");
      check("t2.order", 64'(rsp_id), 64'(order[k]));
      check("t2.nobubble", 64'(rsp_valid), 64'd1);
    end

    // backpressure
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("t3.stall");
      check("t3.ready_c", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step("t3.release");
    check("t3.id_c", 64'(rsp_id), 64'd0);

    // SUB / SLTU compare flags
    set_req(0, 32'h55555, 32'h55555, ALU_SUB, 4'd4);
    req_valid = 2'b01;
    step("t4.sub");
    check("t4.sub_eq", 64'(rsp_eq), 64'd1);
    check("t4.sub_res", 64'(rsp_result), 64'd0);
    set_req(0, 32'h55555, 32'hAAAAA, ALU_SLTU, 4'd5);
    step("t4.sltu");
    check("t4.sltu_res", 64'(rsp_result), 64'd1);
    check("t4.sltu_ltu", 64'(rsp_ltu), 64'd1);

    // illegal opcode from requester 1
    set_req(1, 32'h1234, 32'h1234, 4'd12, 4'd7);
    req_valid = 2'b10;
    step("t5.ill");
    check("t5.err_c", 64'(rsp_err), 64'd1);
    check("t5.id_c", 64'(rsp_id), 64'd1);
    req_valid = 2'b11;
    step("t5.next");
    check("t5.ptr_c", 64'(rsp_id), 64'd0);

    // reset while a response is stalled
    set_req(0, 32'd9, 32'd9, ALU_OR, 4'd6);
    req_valid = 2'b01; rsp_ready = 1'b0;
    step("t6.fill");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6.async_valid", 64'(rsp_valid), 64'd0);
    check("t6.async_ready", 64'(req_ready), 64'd0);
    check_rsp("t6.async");
    @(negedge clk);
    rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    step("t6.after");
    check("t6.first_c", 64'(rsp_id), 64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        logic [31:0] a;
        a = $urandom;
        set_req(i, a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
                4'($urandom_range(0, 15)), TAG_W'($urandom));
      end
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
